// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: shared types and default sizes for the CORDIC request scheduler
package cordic_sched_pkg;
    localparam int LATENCY_DEF    = 10;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int SAMPLE_W       = 4;
    localparam int ANGLE_W        = 16;
    localparam int N_REQ_DEF      = 4;
    localparam int TAG_ID_W       = $clog2(N_REQ_DEF);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/cordic_res_fifo.sv
// cordic_res_fifo: synchronous show-ahead FIFO with occupancy count
module cordic_res_fifo #(
    parameter int W = 18,
    parameter int DEPTH = 16,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one CORDIC pipeline between I/Q requesters
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ID_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [SAMPLE_W*N_REQ-1:0] i_req_I,
    input  logic [SAMPLE_W*N_REQ-1:0] i_req_Q,
    output logic [SAMPLE_W-1:0]       o_cordic_I,
    output logic [SAMPLE_W-1:0]       o_cordic_Q,
    output logic                      o_cordic_rstn,
    input  logic [ANGLE_W-1:0]        i_cordic_angle,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [ID_W-1:0]           o_res_id,
    output logic [ANGLE_W-1:0]        o_res_angle,
    input  logic                      i_enable,
    output logic                      o_busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_t                  state, state_nx;
    logic [ID_W-1:0]         ptr, gnt_id;
    logic                    gnt_any, credit_ok, hs, push, empty, full;
    logic [CW-1:0]           fifo_count, inflight;
    tag_t                    tags [LATENCY];
    logic [1:0]              rstn_sr;
    logic [ID_W+ANGLE_W-1:0] head;
    function automatic logic [ID_W-1:0] wrap(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return ID_W'(s >= N_REQ ? s - N_REQ : s);
    endfunction
    // Scan from the highest offset down so the nearest valid at/after ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (i_req_valid[wrap(ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_id  = wrap(ptr, k);
            end
    end
    assign credit_ok   = int'(fifo_count) + int'(inflight) < FIFO_DEPTH;
    assign hs          = (state == RUN) && credit_ok && gnt_any;
    assign o_req_ready = hs ? N_REQ'(1) << gnt_id : '0;
    assign push        = tags[LATENCY-1].valid;
    assign o_busy      = state != IDLE;
    assign o_cordic_rstn = rstn_sr[1];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_enable) state_nx = RUN;
            RUN:     if (!i_enable) state_nx = DRAIN;
            DRAIN:   if (i_enable) state_nx = RUN;
                     else if (inflight == '0 && empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            inflight   <= '0;
            o_cordic_I <= '0;
            o_cordic_Q <= '0;
            rstn_sr    <= '0;
            for (int k = 0; k < LATENCY; k++) tags[k] <= '0;
        end else begin
            state      <= state_nx;
            rstn_sr    <= {rstn_sr[0], 1'b1};
            inflight   <= inflight + CW'(hs) - CW'(push);
            o_cordic_I <= hs ? i_req_I[int'(gnt_id)*SAMPLE_W +: SAMPLE_W] : '0;
            o_cordic_Q <= hs ? i_req_Q[int'(gnt_id)*SAMPLE_W +: SAMPLE_W] : '0;
            tags[0]    <= hs ? tag_t'{1'b1, TAG_ID_W'(gnt_id)} : '0;
            for (int k = 1; k < LATENCY; k++) tags[k] <= tags[k-1];
            if (hs) ptr <= wrap(gnt_id, 1);
        end
    cordic_res_fifo #(.W(ID_W + ANGLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   ({ID_W'(tags[LATENCY-1].id), i_cordic_angle}),
        .pop   (i_res_ready),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (fifo_count)
    );
    assign o_res_valid = !empty;
    assign o_res_id    = head[ANGLE_W +: ID_W];
    assign o_res_angle = head[ANGLE_W-1:0];
    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full));
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed bench with a 9-stage stand-in for cordic_block
module tb_cordic_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0, req_ready;
    logic [15:0] req_I = '0, req_Q = '0;
    logic [3:0]  c_I, c_Q;
    logic        c_rstn;
    logic [15:0] angle;
    logic        res_valid, res_ready = 1'b0;
    logic [1:0]  res_id;
    logic [15:0] res_angle;
    logic        enable = 1'b0, busy;
    logic [15:0] pipe [9];
    logic [17:0] exp_q [$];
    int          compared = 0, mismatched = 0;

    always #5 clock = ~clock;

    // Stand-in CORDIC: angle tags the sample it came from, 9 edges later.
    always @(posedge clock)
        if (!c_rstn) begin
            for (int i = 0; i < 9; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {c_I, c_Q, 8'h5A};
            for (int i = 1; i < 9; i++) pipe[i] <= pipe[i-1];
        end
    assign angle = pipe[8];

    cordic_sched dut (
        .clock(clock), .reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_I(req_I), .i_req_Q(req_Q), .o_cordic_I(c_I), .o_cordic_Q(c_Q),
        .o_cordic_rstn(c_rstn), .i_cordic_angle(angle), .o_res_valid(res_valid),
        .i_res_ready(res_ready), .o_res_id(res_id), .o_res_angle(res_angle),
        .i_enable(enable), .o_busy(busy)
    );

    task automatic note_hs;
        for (int k = 0; k < 4; k++)
            if (req_ready[k] && req_valid[k])
                exp_q.push_back({2'(k), req_I[4*k +: 4], req_Q[4*k +: 4], 8'h5A});
    endtask

    task automatic collect(input int n);
        int got = 0, guard = 0;
        res_ready = 1'b1;
        while (got < n && guard < 200) begin
            if (res_valid) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL result_extra: got id=%0d angle=%h, want nothing", res_id, res_angle);
                end else begin
                    if ({res_id, res_angle} !== exp_q[0]) begin
                        mismatched++;
                        $display("FAIL result_order: got id=%0d angle=%h, want id=%0d angle=%h",
                                 res_id, res_angle, exp_q[0][17:16], exp_q[0][15:0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            @(negedge clock);
            guard++;
        end
        compared++;
        if (got != n) begin
            mismatched++;
            $display("FAIL result_count: got %0d, want %0d", got, n);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        compared++; if (req_ready !== 4'b0) begin mismatched++; $display("FAIL rst_ready: got %b, want 0000", req_ready); end
        compared++; if ({c_I, c_Q} !== 8'h00) begin mismatched++; $display("FAIL rst_cordic_iq: got %h, want 00", {c_I, c_Q}); end
        compared++; if (c_rstn !== 1'b0) begin mismatched++; $display("FAIL rst_rstn: got %b, want 0", c_rstn); end
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL rst_res_valid: got %b, want 0", res_valid); end
        compared++; if ({res_id, res_angle} !== 18'h0) begin mismatched++; $display("FAIL rst_res_data: got %h, want 0", {res_id, res_angle}); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b, want 0", busy); end
        reset = 1'b0;
        @(negedge clock);
        compared++; if (c_rstn !== 1'b0) begin mismatched++; $display("FAIL rstn_hold: got %b, want 0", c_rstn); end
        @(negedge clock);
        compared++; if (c_rstn !== 1'b1) begin mismatched++; $display("FAIL rstn_release: got %b, want 1", c_rstn); end
        @(negedge clock);
    endtask

    task automatic test_round_robin;
        enable = 1'b1;
        res_ready = 1'b1;
        @(negedge clock);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rr_busy: got %b, want 1", busy); end
        for (int k = 0; k < 4; k++) begin
            req_I[4*k +: 4] = 4'(k + 1);
            req_Q[4*k +: 4] = 4'(k + 9);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            compared++;
            if (req_ready !== 4'(1 << (c % 4))) begin
                mismatched++;
                $display("FAIL rr_grant: cycle %0d got %b, want %b", c, req_ready, 4'(1 << (c % 4)));
            end
            note_hs;
            @(negedge clock);
        end
        req_valid = '0;
        collect(8);
    endtask

    task automatic test_single;
        int lat = 0;
        res_ready = 1'b0;
        req_I[3:0] = 4'd3;
        req_Q[3:0] = 4'd3;
        req_valid = 4'b0001;
        #1;
        compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL single_ready: got %b, want 0001", req_ready); end
        note_hs;
        @(negedge clock);
        req_valid = '0;
        compared++; if ({c_I, c_Q} !== 8'h33) begin mismatched++; $display("FAIL single_issue_iq: got %h, want 33", {c_I, c_Q}); end
        @(negedge clock);
        lat = 1;
        compared++; if ({c_I, c_Q} !== 8'h00) begin mismatched++; $display("FAIL idle_iq_zero: got %h, want 00", {c_I, c_Q}); end
        while (!res_valid && lat < 30) begin
            @(negedge clock);
            lat++;
        end
        compared++; if (lat != 10) begin mismatched++; $display("FAIL single_latency: got %0d, want 10", lat); end
        collect(1);
    endtask

    task automatic test_credit;
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_I[4*k +: 4] = 4'(k + 4);
            req_Q[4*k +: 4] = 4'(15 - k);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            #1;
            note_hs;
            @(negedge clock);
        end
        compared++; if (exp_q.size() != 16) begin mismatched++; $display("FAIL credit_issues: got %0d, want 16", exp_q.size()); end
        #1;
        compared++; if (req_ready !== 4'b0) begin mismatched++; $display("FAIL credit_stall: got %b, want 0000", req_ready); end
        req_valid = '0;
        collect(16);
        req_valid = 4'b0100;
        #1;
        compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL credit_resume: got %b, want 0100", req_ready); end
        note_hs;
        @(negedge clock);
        req_valid = '0;
        collect(1);
    endtask

    task automatic test_drain;
        int bad = 0, w = 0;
        res_ready = 1'b0;
        req_Q[3:0] = 4'd7;
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            req_I[3:0] = 4'(c + 1);
            #1;
            compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL drain_issue: cycle %0d got %b, want 0001", c, req_ready); end
            note_hs;
            @(negedge clock);
        end
        req_valid = '0;
        enable = 1'b0;
        @(negedge clock);
        req_valid = 4'b0001;
        #1;
        compared++; if (req_ready !== 4'b0) begin mismatched++; $display("FAIL drain_no_ready: got %b, want 0000", req_ready); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            #1;
            if (req_ready !== 4'b0 || busy !== 1'b1) bad++;
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL drain_hold: got %0d bad cycles, want 0", bad); end
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL drain_results_ready: got %b, want 1", res_valid); end
        req_valid = '0;
        collect(5);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL drain_busy_last_pop: got %b, want 1", busy); end
        while (busy && w < 5) begin
            @(negedge clock);
            w++;
        end
        compared++; if (busy !== 1'b0 || w != 1) begin mismatched++; $display("FAIL drain_idle: got busy=%b after %0d cycles, want 0 after 1", busy, w); end
        req_valid = 4'b0001;
        #1;
        compared++; if (req_ready !== 4'b0) begin mismatched++; $display("FAIL idle_no_ready: got %b, want 0000", req_ready); end
        req_valid = '0;
        @(negedge clock);
    endtask

    task automatic test_reset_midflight;
        int hs = 0, stale = 0, lat = 0;
        enable = 1'b1;
        res_ready = 1'b1;
        @(negedge clock);
        req_valid = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            req_I[7:4] = 4'(c + 2);
            req_Q[7:4] = 4'(c);
            #1;
            if (req_ready === 4'b0010) hs++;
            @(negedge clock);
        end
        compared++; if (hs != 6) begin mismatched++; $display("FAIL mid_issues: got %0d, want 6", hs); end
        req_valid = '0;
        reset = 1'b1;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_rst_busy: got %b, want 0", busy); end
        compared++; if (c_rstn !== 1'b0) begin mismatched++; $display("FAIL mid_rst_rstn: got %b, want 0", c_rstn); end
        compared++; if ({c_I, c_Q} !== 8'h00) begin mismatched++; $display("FAIL mid_rst_iq: got %h, want 00", {c_I, c_Q}); end
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_res_valid: got %b, want 0", res_valid); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (res_valid) stale++;
        end
        compared++; if (stale != 0) begin mismatched++; $display("FAIL mid_stale: got %0d stale cycles, want 0", stale); end
        req_I[15:12] = 4'd5;
        req_Q[15:12] = 4'd2;
        req_valid = 4'b1000;
        #1;
        compared++; if (req_ready !== 4'b1000) begin mismatched++; $display("FAIL mid_new_ready: got %b, want 1000", req_ready); end
        note_hs;
        @(negedge clock);
        req_valid = '0;
        while (!res_valid && lat < 30) begin
            @(negedge clock);
            lat++;
        end
        compared++; if (lat != 10) begin mismatched++; $display("FAIL mid_new_latency: got %0d, want 10", lat); end
        collect(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_credit;
        test_drain;
        test_reset_midflight;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
